// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0]  PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0]  PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0]  PC_SEL_EXC    = 2'b10;
  localparam logic [1:0]  PC_SEL_EPC    = 2'b11;

  localparam logic [31:0] NOP_INSTR     = 32'h0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: an EX-stage load writing a register the
// ID instruction reads. Writes to $0 never create a hazard.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_GPR_waddr,
  output logic       lu
);

  always_comb begin
    lu = ex_mem_read && (ex_GPR_waddr != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_GPR_waddr)) ||
          (id_uses_rt && (id_rt == ex_GPR_waddr)));
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / MD_WAIT / REDIRECT).
// Optional perf counters are built when PIPECTRL_PERF_EN is defined.
module pipeline_controller
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned MD_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_GPR_waddr,
  input  logic        id_md_start,
  input  logic        md_busy,
  input  logic        md_done,
  input  logic        id_branch_taken,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        if_id_flush,
  output logic        id_ex_ena,
  output logic        id_ex_flush,
  output logic [1:0]  pc_select,
  output logic        md_timeout
`ifdef PIPECTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  state_t     state, state_nx;
  logic [3:0] flush_cnt, flush_nx;
  logic [7:0] md_cnt, md_nx;
  logic       timeout_set;
  logic       use_run;
  logic       lu;

  hazard_detect u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_GPR_waddr (ex_GPR_waddr),
    .lu           (lu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush_cnt  <= '0;
      md_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_nx;
      md_cnt    <= md_nx;
      if (timeout_set) md_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    flush_nx    = flush_cnt;
    md_nx       = md_cnt;
    timeout_set = 1'b0;
    use_run     = 1'b0;
    pc_ena      = 1'b1;
    if_id_ena   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_ena   = 1'b1;
    id_ex_flush = 1'b0;
    pc_select   = PC_SEL_SEQ;

    // Non-RUN states either hold their own outputs or fall through to the
    // RUN priority chain below (preempting exception, MD release).
    unique case (state)
      MD_WAIT: begin
        if (exc_req || md_done) begin
          use_run = 1'b1;
        end else begin
          pc_ena      = 1'b0;
          if_id_ena   = 1'b0;
          id_ex_flush = 1'b1;
          if (md_cnt == 8'(MD_TIMEOUT - 1)) begin
            timeout_set = 1'b1;
            state_nx    = RUN;
          end else begin
            md_nx = md_cnt + 8'd1;
          end
        end
      end
      REDIRECT: begin
        if (exc_req) begin
          use_run = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_nx    = flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) state_nx = RUN;
        end
      end
      default: use_run = 1'b1;
    endcase

    if (use_run) begin
      state_nx = RUN;
      if (exc_req || eret_req) begin
        pc_select   = exc_req ? PC_SEL_EXC : PC_SEL_EPC;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_nx    = 4'(FLUSH_DEPTH - 1);
        if (FLUSH_DEPTH > 1) state_nx = REDIRECT;
      end else if (id_md_start && md_busy && !md_done) begin
        pc_ena      = 1'b0;
        if_id_ena   = 1'b0;
        id_ex_flush = 1'b1;
        md_nx       = '0;
        state_nx    = MD_WAIT;
      end else if (lu) begin
        pc_ena      = 1'b0;
        if_id_ena   = 1'b0;
        id_ex_flush = 1'b1;
      end else if (id_branch_taken) begin
        pc_select   = PC_SEL_BRANCH;
        if_id_flush = 1'b1;
      end
    end

    if (reset) begin
      pc_ena      = 1'b0;
      if_id_ena   = 1'b0;
      id_ex_ena   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_select   = PC_SEL_SEQ;
    end
  end

`ifdef PIPECTRL_PERF_EN
  // A non-sequential pc_select outside reset marks a fresh redirect or branch flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_ena && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if ((pc_select != PC_SEL_SEQ) && (flush_events != '1))
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller (default parameters).
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_GPR_waddr;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       id_md_start, md_busy, md_done, id_branch_taken, exc_req, eret_req;
  logic       pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush, md_timeout;
  logic [1:0] pc_select;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  // {pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush, pc_select}
  localparam logic [6:0] O_RUN   = 7'b1101000;
  localparam logic [6:0] O_STALL = 7'b0001100;
  localparam logic [6:0] O_BR    = 7'b1111001;
  localparam logic [6:0] O_EXC   = 7'b1111110;
  localparam logic [6:0] O_ERET  = 7'b1111111;
  localparam logic [6:0] O_RDR   = 7'b1111100;
  localparam logic [6:0] O_RST   = 7'b0010100;

  assign outs = {pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush, pc_select};

  always #5 clk = ~clk;

  pipeline_controller #(.FLUSH_DEPTH(2), .MD_TIMEOUT(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_GPR_waddr    (ex_GPR_waddr),
    .id_md_start     (id_md_start),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .id_branch_taken (id_branch_taken),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .pc_ena          (pc_ena),
    .if_id_ena       (if_id_ena),
    .if_id_flush     (if_id_flush),
    .id_ex_ena       (id_ex_ena),
    .id_ex_flush     (id_ex_flush),
    .pc_select       (pc_select),
    .md_timeout      (md_timeout)
  );

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_GPR_waddr = 5'd0;
    id_md_start = 1'b0; md_busy = 1'b0; md_done = 1'b0;
    id_branch_taken = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (outs !== O_RST) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
    checks++;
    if (md_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", md_timeout); end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, O_RUN); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_GPR_waddr = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5; #1;
    checks++;
    if (outs !== O_STALL) begin errors++; $display("FAIL lu_rs got=%b exp=%b", outs, O_STALL); end
    @(negedge clk);
    ex_mem_read = 1'b0; #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL lu_after got=%b exp=%b", outs, O_RUN); end
    @(negedge clk);
    ex_mem_read = 1'b1; ex_GPR_waddr = 5'd0; id_rs = 5'd0; #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL lu_r0 got=%b exp=%b", outs, O_RUN); end
    @(negedge clk);
    id_uses_rs = 1'b0; id_rs = 5'd7; id_rt = 5'd7; ex_GPR_waddr = 5'd7; #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL lu_unused got=%b exp=%b", outs, O_RUN); end
    id_uses_rt = 1'b1; #1;
    checks++;
    if (outs !== O_STALL) begin errors++; $display("FAIL lu_rt got=%b exp=%b", outs, O_STALL); end
    @(negedge clk);
    idle_inputs(); #1;
  endtask

  task automatic test_md_done();
    int holds = 0;
    @(negedge clk);
    id_md_start = 1'b1; md_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      if (outs === O_STALL) holds++;
    end
    checks++;
    if (holds !== 10) begin errors++; $display("FAIL md_holds got=%0d exp=10", holds); end
    @(negedge clk);
    md_done = 1'b1; md_busy = 1'b0; #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL md_release got=%b exp=%b", outs, O_RUN); end
    @(negedge clk);
    idle_inputs(); #1;
    checks++;
    if (outs !== O_RUN || md_timeout !== 1'b0) begin
      errors++; $display("FAIL md_after got=%b/%b exp=%b/0", outs, md_timeout, O_RUN);
    end
  endtask

  task automatic test_md_timeout();
    int holds = 0;
    int early = 0;
    @(negedge clk);
    id_md_start = 1'b1; md_busy = 1'b1; #1;
    checks++;
    if (outs !== O_STALL) begin errors++; $display("FAIL to_entry got=%b exp=%b", outs, O_STALL); end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (outs === O_STALL) holds++;
      if (md_timeout !== 1'b0) early++;
    end
    checks++;
    if (holds !== 64 || early !== 0) begin
      errors++; $display("FAIL to_wait holds=%0d early=%0d exp=64/0", holds, early);
    end
    @(negedge clk);
    idle_inputs(); #1;
    checks++;
    if (md_timeout !== 1'b1 || outs !== O_RUN) begin
      errors++; $display("FAIL to_set got=%b/%b exp=1/%b", md_timeout, outs, O_RUN);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (md_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", md_timeout); end
  endtask

  task automatic test_redirect(input logic exc, input logic eret, input logic [6:0] first);
    @(negedge clk);
    exc_req = exc; eret_req = eret; #1;
    checks++;
    if (outs !== first) begin errors++; $display("FAIL redir_first got=%b exp=%b", outs, first); end
    @(negedge clk);
    idle_inputs(); #1;
    checks++;
    if (outs !== O_RDR) begin errors++; $display("FAIL redir_hold got=%b exp=%b", outs, O_RDR); end
    @(negedge clk); #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL redir_done got=%b exp=%b", outs, O_RUN); end
  endtask

  task automatic test_exc_in_md();
    @(negedge clk);
    id_md_start = 1'b1; md_busy = 1'b1;
    @(negedge clk);
    exc_req = 1'b1; #1;
    checks++;
    if (outs !== O_EXC) begin errors++; $display("FAIL md_exc got=%b exp=%b", outs, O_EXC); end
    @(negedge clk);
    idle_inputs(); #1;
    checks++;
    if (outs !== O_RDR) begin errors++; $display("FAIL md_exc_rdr got=%b exp=%b", outs, O_RDR); end
    @(negedge clk); #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL md_exc_run got=%b exp=%b", outs, O_RUN); end
  endtask

  task automatic test_lu_branch();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_GPR_waddr = 5'd9; id_uses_rs = 1'b1; id_rs = 5'd9;
    id_branch_taken = 1'b1; #1;
    checks++;
    if (outs !== O_STALL) begin errors++; $display("FAIL lubr_stall got=%b exp=%b", outs, O_STALL); end
    @(negedge clk);
    ex_mem_read = 1'b0; #1;
    checks++;
    if (outs !== O_BR) begin errors++; $display("FAIL lubr_branch got=%b exp=%b", outs, O_BR); end
    @(negedge clk);
    idle_inputs(); #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL lubr_run got=%b exp=%b", outs, O_RUN); end
  endtask

  task automatic test_reset_mid_seq();
    @(negedge clk);
    id_md_start = 1'b1; md_busy = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; idle_inputs(); #1;
    checks++;
    if (outs !== O_RST) begin errors++; $display("FAIL rstmd_force got=%b exp=%b", outs, O_RST); end
    @(negedge clk);
    reset = 1'b0; #1;
    checks++;
    if (outs !== O_RUN || md_timeout !== 1'b0) begin
      errors++; $display("FAIL rstmd_release got=%b/%b exp=%b/0", outs, md_timeout, O_RUN);
    end
    @(negedge clk);
    exc_req = 1'b1;
    @(negedge clk);
    exc_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    checks++;
    if (outs !== O_RUN) begin errors++; $display("FAIL rstrdr_release got=%b exp=%b", outs, O_RUN); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md_done();
    test_md_timeout();
    test_redirect(1'b1, 1'b0, O_EXC);
    test_redirect(1'b0, 1'b1, O_ERET);
    test_redirect(1'b1, 1'b1, O_EXC);
    test_exc_in_md();
    test_lu_branch();
    test_reset_mid_seq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
